// File: rtl/proc_ctrl_if.sv
// ============================================================================
// Module      : proc_ctrl_if
// Description : Run/instruction inputs and datapath control strobes of the
//               proc_ctrl sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface proc_ctrl_if;
    logic       run;
    logic [8:0] din;
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic       addsub;
    logic       done;

    modport master (
        output run, din,
        input  irin, rin, rout, ain, gin, gout, dinout, addsub, done
    );

    modport slave (
        input  run, din,
        output irin, rin, rout, ain, gin, gout, dinout, addsub, done
    );
endinterface

`default_nettype wire

// File: rtl/proc_ctrl.sv
// ============================================================================
// Module      : proc_ctrl
// Description : Four-step control sequencer for a 9-bit mv/mvi/add/sub core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_ctrl (
    input  wire logic    clk,
    input  wire logic    rst,
    proc_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] c_op_mv  = 3'b000;
    localparam logic [2:0] c_op_mvi = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_sub = 3'b011;

    state_t     r_state;
    logic [8:0] r_ir;

    logic [2:0] w_op;
    logic [7:0] w_xsel;
    logic [7:0] w_ysel;
    logic       w_arith;

    assign w_op    = r_ir[8:6];
    assign w_xsel  = 8'b0000_0001 << r_ir[5:3];
    assign w_ysel  = 8'b0000_0001 << r_ir[2:0];
    assign w_arith = (w_op == c_op_add) || (w_op == c_op_sub);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= T0;
            r_ir    <= 9'd0;
        end else begin
            case (r_state)
                T0: begin
                    if (bus.run) begin
                        r_ir    <= bus.din;
                        r_state <= T1;
                    end
                end
                T1:      r_state <= w_arith ? T2 : T0;
                T2:      r_state <= T3;
                T3:      r_state <= T0;
                default: r_state <= T0;
            endcase
        end
    end

    // Outputs are decoded directly from state so they hold off while rst is high.
    always_comb begin
        bus.irin   = 1'b0;
        bus.rin    = 8'd0;
        bus.rout   = 8'd0;
        bus.ain    = 1'b0;
        bus.gin    = 1'b0;
        bus.gout   = 1'b0;
        bus.dinout = 1'b0;
        bus.addsub = 1'b0;
        bus.done   = 1'b0;
        if (!rst) begin
            case (r_state)
                T0: bus.irin = bus.run;
                T1: begin
                    case (w_op)
                        c_op_mv: begin
                            bus.rout = w_ysel;
                            bus.rin  = w_xsel;
                            bus.done = 1'b1;
                        end
                        c_op_mvi: begin
                            bus.dinout = 1'b1;
                            bus.rin    = w_xsel;
                            bus.done   = 1'b1;
                        end
                        c_op_add, c_op_sub: begin
                            bus.rout = w_xsel;
                            bus.ain  = 1'b1;
                        end
                        default: bus.done = 1'b1;
                    endcase
                end
                T2: begin
                    bus.rout   = w_ysel;
                    bus.gin    = 1'b1;
                    bus.addsub = (w_op == c_op_sub);
                end
                T3: begin
                    bus.gout = 1'b1;
                    bus.rin  = w_xsel;
                    bus.done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_proc_ctrl.sv
// ============================================================================
// Module      : tb_proc_ctrl
// Description : Directed self-checking bench for the proc_ctrl sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    proc_ctrl_if bus_if ();

    proc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {irin, rin, rout, ain, gin, gout, dinout, addsub, done}
    logic [22:0] obs;
    assign obs = {bus_if.irin, bus_if.rin, bus_if.rout, bus_if.ain, bus_if.gin,
                  bus_if.gout, bus_if.dinout, bus_if.addsub, bus_if.done};

    function automatic logic [22:0] ev(input logic irin, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic ain,
                                       input logic gin, input logic gout,
                                       input logic dinout, input logic addsub,
                                       input logic done);
        return {irin, rin, rout, ain, gin, gout, dinout, addsub, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        logic [22:0] e;
        rst = 1'b1; bus_if.run = 1'b1; bus_if.din = 9'h040;
        tick(); #1;
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_outs got=%h exp=%h", obs, e); end
        total++;
        if (dut.r_ir !== 9'd0) begin bad++; $display("FAIL reset_ir got=%h exp=000", dut.r_ir); end
        rst = 1'b0; bus_if.run = 1'b0;
        tick(); #1;
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_idle got=%h exp=%h", obs, e); end
    endtask

    task automatic test_mvi();
        logic [22:0] e;
        bus_if.run = 1'b1; bus_if.din = 9'h040; #1;
        e = ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL mvi_t0 got=%h exp=%h", obs, e); end
        tick();
        bus_if.run = 1'b0; bus_if.din = 9'h005; #1;
        e = ev(0, 8'h01, 8'h00, 0, 0, 0, 1, 0, 1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL mvi_t1 got=%h exp=%h", obs, e); end
        tick(); #1;
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL mvi_back_t0 got=%h exp=%h", obs, e); end
    endtask

    task automatic test_mv();
        logic [22:0] e;
        bus_if.run = 1'b1; bus_if.din = 9'h008;
        tick();
        bus_if.run = 1'b0; bus_if.din = 9'h1FF; #1;
        e = ev(0, 8'h02, 8'h01, 0, 0, 0, 0, 0, 1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL mv_t1 got=%h exp=%h", obs, e); end
        tick(); #1;
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL mv_back_t0 got=%h exp=%h", obs, e); end
    endtask

    task automatic test_arith(input logic [8:0] instr, input logic [7:0] xs,
                              input logic [7:0] ys, input logic sub, input string nm);
        logic [22:0] e;
        bus_if.run = 1'b1; bus_if.din = instr;
        tick();
        // Run and DIN must be ignored while the instruction executes.
        bus_if.run = 1'b1; bus_if.din = 9'h040; #1;
        e = ev(0, 8'h00, xs, 1, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL %s_t1 got=%h exp=%h", nm, obs, e); end
        tick(); #1;
        e = ev(0, 8'h00, ys, 0, 1, 0, 0, sub, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL %s_t2 got=%h exp=%h", nm, obs, e); end
        tick();
        bus_if.run = 1'b0; #1;
        e = ev(0, xs, 8'h00, 0, 0, 1, 0, 0, 1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL %s_t3 got=%h exp=%h", nm, obs, e); end
        tick(); #1;
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL %s_back_t0 got=%h exp=%h", nm, obs, e); end
    endtask

    task automatic test_reset_mid();
        logic [22:0] e;
        bus_if.run = 1'b1; bus_if.din = 9'h081;
        tick();
        bus_if.run = 1'b0;
        tick();
        rst = 1'b1; #1;
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL rstmid_during got=%h exp=%h", obs, e); end
        tick();
        rst = 1'b0; #1;
        total++;
        if (obs !== e) begin bad++; $display("FAIL rstmid_after got=%h exp=%h", obs, e); end
        total++;
        if (dut.r_ir !== 9'd0) begin bad++; $display("FAIL rstmid_ir got=%h exp=000", dut.r_ir); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            total++;
            if (obs !== e) begin bad++; $display("FAIL rstmid_quiet%0d got=%h exp=%h", i, obs, e); end
        end
    endtask

    task automatic test_idle_nop();
        logic [22:0] e;
        bus_if.run = 1'b0; bus_if.din = 9'h081;
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            total++;
            if (obs !== e) begin bad++; $display("FAIL idle%0d got=%h exp=%h", i, obs, e); end
        end
        bus_if.run = 1'b1; bus_if.din = 9'h1C0;
        tick();
        bus_if.run = 1'b0; #1;
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL nop_t1 got=%h exp=%h", obs, e); end
        tick(); #1;
        e = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL nop_back_t0 got=%h exp=%h", obs, e); end
    endtask

    task automatic test_back_to_back();
        logic [22:0] e;
        bus_if.run = 1'b1; bus_if.din = 9'h008;
        tick();
        bus_if.din = 9'h092; #1;
        e = ev(0, 8'h02, 8'h01, 0, 0, 0, 0, 0, 1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL b2b_mv got=%h exp=%h", obs, e); end
        tick(); #1;
        e = ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL b2b_accept got=%h exp=%h", obs, e); end
        tick();
        bus_if.run = 1'b0; #1;
        e = ev(0, 8'h00, 8'h04, 1, 0, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL b2b_add_t1 got=%h exp=%h", obs, e); end
        tick(); #1;
        e = ev(0, 8'h00, 8'h04, 0, 1, 0, 0, 0, 0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL b2b_add_t2 got=%h exp=%h", obs, e); end
        tick(); #1;
        e = ev(0, 8'h04, 8'h00, 0, 0, 1, 0, 0, 1);
        total++;
        if (obs !== e) begin bad++; $display("FAIL b2b_add_t3 got=%h exp=%h", obs, e); end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_if.run = 1'b0;
        bus_if.din = 9'd0;
        test_reset();
        test_mvi();
        test_mv();
        test_arith(9'h081, 8'h01, 8'h02, 1'b0, "add");
        test_arith(9'h0FB, 8'h80, 8'h08, 1'b1, "sub");
        test_reset_mid();
        test_idle_nop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
